// File: rtl/mext_pkg.sv
// mext_pkg: shared types and constants for the RV32M execute unit.
//   mext_op_t    - operation code, encoded as the RV32M funct3 field
//   mext_state_t - control FSM states of mext_unit
//   mext_abs     - two's complement magnitude of a 32-bit value
package mext_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mext_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL1,
        ST_DIV_KICK,
        ST_DIV_WAIT,
        ST_DONE
    } mext_state_t;

    localparam logic [31:0] MEXT_INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] MEXT_ALL_ONES = 32'hFFFF_FFFF;

    function automatic logic [31:0] mext_abs(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/div.sv
// div: iterative radix-2 restoring divider, one quotient bit per cycle.
//   clk, reset          - clock, synchronous active-high reset
//   kick                - start a division (taken only while ready=1)
//   unsigned_flag       - 1: operands unsigned, 0: two's complement
//   dividend, divisor   - operands, sampled on the kick edge
//   quotient, remainder - results, valid while ready=1 after a run
//   ready               - idle; drops on the edge after kick, returns 32 edges later
//   ready_pre           - ready will rise on the next edge
module div (
    input  logic        clk,
    input  logic        reset,
    input  logic        kick,
    input  logic        unsigned_flag,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        ready,
    output logic        ready_pre
);

    logic        r_busy;
    logic [4:0]  r_cnt;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_den;
    logic        r_neg_q;
    logic        r_neg_r;

    logic        w_dvd_neg;
    logic        w_dvs_neg;
    logic [32:0] w_shift;
    logic [33:0] w_diff;

    assign w_dvd_neg = !unsigned_flag && dividend[31];
    assign w_dvs_neg = !unsigned_flag && divisor[31];

    // Partial remainder shifted left with the next dividend bit; bit 33 of the
    // difference is the borrow that decides the quotient bit.
    assign w_shift = {r_rem, r_quo[31]};
    assign w_diff  = {1'b0, w_shift} - {2'b00, r_den};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy  <= 1'b0;
            r_cnt   <= 5'd0;
            r_quo   <= 32'd0;
            r_rem   <= 32'd0;
            r_den   <= 32'd0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (kick && !r_busy) begin
            r_busy  <= 1'b1;
            r_cnt   <= 5'd0;
            r_quo   <= w_dvd_neg ? (~dividend + 32'd1) : dividend;
            r_rem   <= 32'd0;
            r_den   <= w_dvs_neg ? (~divisor + 32'd1) : divisor;
            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r <= w_dvd_neg;
        end else if (r_busy) begin
            r_rem <= w_diff[33] ? w_shift[31:0] : w_diff[31:0];
            r_quo <= {r_quo[30:0], ~w_diff[33]};
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign quotient  = r_neg_q ? (~r_quo + 32'd1) : r_quo;
    assign remainder = r_neg_r ? (~r_rem + 32'd1) : r_rem;
    assign ready     = !r_busy;
    assign ready_pre = r_busy && (r_cnt == 5'd31);

endmodule

// File: rtl/mext_unit.sv
// mext_unit: multi-cycle RV32M execute unit (MUL*/DIV*/REM*), one op in flight.
//   clk, reset                 - clock, synchronous active-high reset
//   in_valid / in_ready        - request handshake; in_ready only in IDLE
//   in_op, in_rs1, in_rs2      - operation and operands
//   in_tag                     - opaque tag returned with the result
//   out_valid / out_ready      - result handshake; result held until taken
//   out_result, out_tag        - registered result and its tag
// Multiplies take MUL1 then DONE; divides run the div core on magnitudes and
// fix the signs here. Divide-by-zero and INT_MIN/-1 bypass the core.
module mext_unit
    import mext_pkg::*;
#(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  mext_op_t         in_op,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag
);

    mext_state_t      r_state;
    mext_op_t         r_op;
    logic [31:0]      r_rs1;
    logic [31:0]      r_rs2;
    logic             r_kick;
    logic             r_out_valid;
    logic [31:0]      r_out_result;
    logic [TAG_W-1:0] r_out_tag;

    logic               w_in_mul;
    logic               w_in_div;
    logic               w_in_sdiv;
    logic               w_sdiv;
    logic signed [32:0] w_mul_a;
    logic signed [32:0] w_mul_b;
    logic signed [63:0] w_prod;
    logic [31:0]        w_div_a;
    logic [31:0]        w_div_b;
    logic [31:0]        w_div_q;
    logic [31:0]        w_div_r;
    logic               w_div_ready;
    logic               w_neg_q;
    logic               w_neg_r;

    assign w_in_mul  = !in_op[2];
    assign w_in_div  = (in_op == OP_DIV) || (in_op == OP_DIVU);
    assign w_in_sdiv = (in_op == OP_DIV) || (in_op == OP_REM);
    assign w_sdiv    = (r_op == OP_DIV) || (r_op == OP_REM);

    // 33-bit operands: the extra bit is the sign for signed sources and 0 otherwise,
    // so one signed multiplier covers all four variants. Only 64 product bits matter.
    assign w_mul_a = {((r_op == OP_MULH) || (r_op == OP_MULHSU)) & r_rs1[31], r_rs1};
    assign w_mul_b = {(r_op == OP_MULH) & r_rs2[31], r_rs2};
    assign w_prod  = 64'(w_mul_a) * 64'(w_mul_b);

    assign w_div_a = w_sdiv ? mext_abs(r_rs1) : r_rs1;
    assign w_div_b = w_sdiv ? mext_abs(r_rs2) : r_rs2;
    assign w_neg_q = w_sdiv && (r_rs1[31] ^ r_rs2[31]);
    assign w_neg_r = w_sdiv && r_rs1[31];

    div u_div (
        .clk          (clk),
        .reset        (reset),
        .kick         (r_kick),
        .unsigned_flag(1'b1),
        .dividend     (w_div_a),
        .divisor      (w_div_b),
        .quotient     (w_div_q),
        .remainder    (w_div_r),
        .ready        (w_div_ready),
        .ready_pre    ()
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_op         <= OP_MUL;
            r_rs1        <= 32'd0;
            r_rs2        <= 32'd0;
            r_kick       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_result <= 32'd0;
            r_out_tag    <= '0;
        end else begin
            r_kick <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_op      <= in_op;
                        r_rs1     <= in_rs1;
                        r_rs2     <= in_rs2;
                        r_out_tag <= in_tag;
                        if (w_in_mul) begin
                            r_state <= ST_MUL1;
                        end else if (in_rs2 == 32'd0) begin
                            r_out_result <= w_in_div ? MEXT_ALL_ONES : in_rs1;
                            r_out_valid  <= 1'b1;
                            r_state      <= ST_DONE;
                        end else if (w_in_sdiv && (in_rs1 == MEXT_INT_MIN) &&
                                     (in_rs2 == MEXT_ALL_ONES)) begin
                            r_out_result <= (in_op == OP_DIV) ? MEXT_INT_MIN : 32'd0;
                            r_out_valid  <= 1'b1;
                            r_state      <= ST_DONE;
                        end else begin
                            r_kick  <= 1'b1;
                            r_state <= ST_DIV_KICK;
                        end
                    end
                end
                ST_MUL1: begin
                    r_out_result <= (r_op == OP_MUL) ? w_prod[31:0] : w_prod[63:32];
                    r_out_valid  <= 1'b1;
                    r_state      <= ST_DONE;
                end
                // The core samples kick on the edge leaving this state, so its ready
                // is only trustworthy from DIV_WAIT onwards.
                ST_DIV_KICK: begin
                    r_state <= ST_DIV_WAIT;
                end
                ST_DIV_WAIT: begin
                    if (w_div_ready) begin
                        if (r_op[1]) begin
                            r_out_result <= w_neg_r ? (~w_div_r + 32'd1) : w_div_r;
                        end else begin
                            r_out_result <= w_neg_q ? (~w_div_q + 32'd1) : w_div_q;
                        end
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = (r_state == ST_IDLE) && !reset;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_tag    = r_out_tag;

endmodule

// File: tb/tb_mext_unit.sv
// tb_mext_unit: directed-vector scoreboard bench for mext_unit.
// The driver pushes hand-computed results, tags and latencies; the monitor pops
// and compares on each output handshake. Latency counts from the accept edge to
// the first edge that samples out_valid high.
module tb_mext_unit;
    import mext_pkg::*;

    localparam int unsigned TAG_W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    mext_op_t         in_op;
    logic [31:0]      in_rs1;
    logic [31:0]      in_rs2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;

    mext_unit #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    int unsigned cyc   = 0;
    int unsigned kicks = 0;
    int          errors = 0;
    int          checks = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dut.u_div.kick) kicks <= kicks + 1;
    end

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        int unsigned      acc;
        int unsigned      lat;
        string            name;
    } exp_t;

    exp_t sb[$];

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endfunction

    // Monitor
    logic        seen = 1'b0;
    int unsigned seen_cyc = 0;
    always @(negedge clk) begin
        if (reset) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (!seen) begin
                seen     = 1'b1;
                seen_cyc = cyc;
            end
            if (out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got result %h tag %0d, required no output",
                             out_result, out_tag);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.name, "_result"}, out_result, e.res);
                    chk({e.name, "_tag"}, 32'(out_tag), 32'(e.tag));
                    chk({e.name, "_latency"}, seen_cyc - e.acc + 1, e.lat);
                end
                seen = 1'b0;
            end
        end
    end

    task automatic issue(input mext_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag, input logic [31:0] res,
                         input int unsigned lat, input string name, input bit push);
        int n = 0;
        exp_t e;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk({name, "_accept_timeout"}, 32'(in_ready), 32'd1);
            return;
        end
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_tag   = tag;
        e.res  = res;
        e.tag  = tag;
        e.acc  = cyc + 1;
        e.lat  = lat;
        e.name = name;
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_rs1   = $urandom;
        in_rs2   = $urandom;
        in_tag   = TAG_W'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned k0;
        int          n;
        int          vcount;
        logic [31:0] hold_res;
        logic [TAG_W-1:0] hold_tag;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = OP_MUL;
        in_rs1    = 32'd0;
        in_rs2    = 32'd0;
        in_tag    = '0;
        out_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_result", out_result, 32'd0);
        chk("reset_out_tag", 32'(out_tag), 32'd0);
        reset = 1'b0;
        #1;
        chk("in_ready_after_reset", 32'(in_ready), 32'd1);

        // Multiplies
        issue(OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 2, "mulh_min", 1);
        issue(OP_MUL,    32'h8000_0000, 32'h8000_0000, 5'd2, 32'h0000_0000, 2, "mul_min", 1);
        issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 2, "mulhsu_ones", 1);
        issue(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, 2, "mulhu_ones", 1);
        issue(OP_MUL,    32'd7,         32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 2, "mul_7xm3", 1);
        drain();

        // Special-case divides never start the core
        k0 = kicks;
        issue(OP_DIVU, 32'd5,         32'd0,         5'd6, 32'hFFFF_FFFF, 1, "divu_by0", 1);
        issue(OP_REMU, 32'd5,         32'd0,         5'd7, 32'd5,         1, "remu_by0", 1);
        issue(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 1, "div_ovf", 1);
        issue(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'd0,         1, "rem_ovf", 1);
        drain();
        chk("no_kick_special", kicks, k0);

        // Signed divide/remainder sign rules
        issue(OP_DIV,  32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFD, 35, "div_m7_2", 1);
        issue(OP_REM,  32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFF, 35, "rem_m7_2", 1);
        issue(OP_REM,  32'd7,         32'hFFFF_FFFE, 5'd12, 32'd1,         35, "rem_7_m2", 1);
        issue(OP_REM,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd13, 32'hFFFF_FFFF, 35, "rem_m7_m2", 1);
        issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1,         5'd14, 32'hFFFF_FFFF, 35, "divu_max_1", 1);
        drain();
        chk("kick_count", kicks, k0 + 5);

        // Backpressure
        out_ready = 1'b0;
        issue(OP_MUL, 32'd6, 32'd7, 5'd15, 32'd42, 2, "mul_bp", 1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        hold_res = 32'd42;
        hold_tag = 5'd15;
        in_valid = 1'b1;
        in_op    = OP_MULHU;
        in_rs1   = 32'h1234_5678;
        in_rs2   = 32'h9ABC_DEF0;
        in_tag   = 5'd30;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_result_stable", out_result, hold_res);
            chk("bp_tag_stable", 32'(out_tag), 32'(hold_tag));
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            chk("bp_valid_held", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_in_ready_after", 32'(in_ready), 32'd1);
        chk("bp_valid_dropped", 32'(out_valid), 32'd0);
        drain();

        // Reset mid-divide discards the operation
        issue(OP_DIVU, 32'd100, 32'd7, 5'd16, 32'd14, 35, "divu_aborted", 0);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        vcount = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        chk("no_out_after_reset", vcount, 32'd0);
        issue(OP_DIVU, 32'd100, 32'd7, 5'd17, 32'd14, 35, "divu_100_7", 1);
        issue(OP_REMU, 32'd100, 32'd7, 5'd18, 32'd2,  35, "remu_100_7", 1);
        drain();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
